// File: rtl/keyloop_recorder_if.sv
`default_nettype none
// ============================================================================
// Module   : keyloop_recorder_if
// Brief    : Control, live-key and status bundle of the key-pattern recorder.
// Revision : 1.0  initial release
// ============================================================================
interface keyloop_recorder_if #(
  parameter int KEY_W  = 4,
  parameter int ADDR_W = 5
);
  logic              go;
  logic              stop;
  logic              loop;
  logic [KEY_W-1:0]  keys;
  logic [1:0]        mode;
  logic              recording;
  logic              playing_back;
  logic [KEY_W-1:0]  play_keys;
  logic [ADDR_W-1:0] slot;
  logic [ADDR_W:0]   rec_len;
  logic              done;

  modport master (
    output go, stop, loop, keys,
    input  mode, recording, playing_back, play_keys, slot, rec_len, done
  );

  modport slave (
    input  go, stop, loop, keys,
    output mode, recording, playing_back, play_keys, slot, rec_len, done
  );
endinterface
`default_nettype wire

// File: rtl/keyloop_recorder.sv
`default_nettype none
// ============================================================================
// Module   : keyloop_recorder
// Brief    : Samples the key vector once per tick into a slot memory, then
//            replays it one-shot or looped; supports early stop and erase.
// Revision : 1.0  initial release
// ============================================================================
module keyloop_recorder #(
  parameter int KEY_W    = 4,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 50000000
) (
  input wire logic          clock,
  input wire logic          reset,
  keyloop_recorder_if.slave bus
);

  localparam int                CNT_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  c_tick_last = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] c_slot_last = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_full_len  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM_REC  = 3'd1,
    S_REC      = 3'd2,
    S_READY    = 3'd3,
    S_ARM_PLAY = 3'd4,
    S_PLAY     = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_slot;
  logic [ADDR_W-1:0] w_slot_nxt;
  logic [ADDR_W:0]   r_rec_len;
  logic [ADDR_W:0]   w_rec_len_nxt;
  logic [KEY_W-1:0]  r_play_keys;
  logic [KEY_W-1:0]  w_play_keys_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_we;
  logic              w_tick;
  logic              w_last_play;
  logic [KEY_W-1:0]  w_mem_rd;
  logic [1:0]        w_mode;

  logic [KEY_W-1:0]  r_mem [DEPTH];

  assign w_tick      = (r_cnt == c_tick_last);
  assign w_last_play = (({1'b0, r_slot} + (ADDR_W + 1)'(1)) == r_rec_len);
  assign w_mem_rd    = r_mem[r_slot];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_slot_nxt      = r_slot;
    w_rec_len_nxt   = r_rec_len;
    w_play_keys_nxt = '0;
    w_done_nxt      = 1'b0;
    w_we            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!bus.go) begin
          w_state_nxt = S_ARM_REC;
        end
      end

      S_ARM_REC: begin
        if (bus.go) begin
          w_state_nxt = S_REC;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      end

      S_REC: begin
        w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
        // Stop discards the partially sampled slot, even on a tick cycle.
        if (bus.stop) begin
          w_rec_len_nxt = {1'b0, r_slot};
          if (r_slot != '0) begin
            w_state_nxt = S_READY;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_tick) begin
          w_we = 1'b1;
          if (r_slot == c_slot_last) begin
            w_rec_len_nxt = c_full_len;
            w_done_nxt    = 1'b1;
            w_state_nxt   = S_READY;
          end else begin
            w_slot_nxt = r_slot + ADDR_W'(1);
          end
        end
      end

      S_READY: begin
        if (bus.stop) begin
          w_state_nxt   = S_IDLE;
          w_rec_len_nxt = '0;
        end else if (!bus.go) begin
          w_state_nxt = S_ARM_PLAY;
        end
      end

      S_ARM_PLAY: begin
        if (bus.go) begin
          w_state_nxt = S_PLAY;
          w_slot_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      end

      S_PLAY: begin
        w_cnt_nxt       = w_tick ? '0 : r_cnt + CNT_W'(1);
        w_play_keys_nxt = w_mem_rd;
        if (bus.stop) begin
          w_state_nxt     = S_READY;
          w_play_keys_nxt = '0;
        end else if (w_tick) begin
          if (w_last_play) begin
            if (bus.loop) begin
              w_slot_nxt = '0;
            end else begin
              w_state_nxt     = S_READY;
              w_done_nxt      = 1'b1;
              w_play_keys_nxt = '0;
            end
          end else begin
            w_slot_nxt = r_slot + ADDR_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_slot      <= '0;
      r_rec_len   <= '0;
      r_play_keys <= '0;
      r_done      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_slot      <= w_slot_nxt;
      r_rec_len   <= w_rec_len_nxt;
      r_play_keys <= w_play_keys_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Pattern memory is never reset; rec_len bounds what playback may read.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[r_slot] <= bus.keys;
    end
  end

  always_comb begin
    w_mode = 2'b00;
    case (r_state)
      S_REC:   w_mode = 2'b01;
      S_PLAY:  w_mode = 2'b10;
      S_READY: w_mode = 2'b11;
      default: w_mode = 2'b00;
    endcase
  end

  assign bus.mode         = w_mode;
  assign bus.recording    = (r_state == S_REC);
  assign bus.playing_back = (r_state == S_PLAY);
  assign bus.play_keys    = r_play_keys;
  assign bus.slot         = r_slot;
  assign bus.rec_len      = r_rec_len;
  assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keyloop_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyloop_recorder
// Brief    : Self-checking bench: vector table, directed takes, random vs model.
// Revision : 1.0  initial release
// ============================================================================
module tb_keyloop_recorder;
  localparam int KEY_W = 4, DEPTH = 8, ADDR_W = 3, TICK_DIV = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  keyloop_recorder_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();

  keyloop_recorder #(.KEY_W(KEY_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_press();
    bus.go = 1'b0;
    step();
    bus.go = 1'b1;
    step();
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_ARM_REC, M_REC, M_READY, M_ARM_PLAY, M_PLAY} mphase_t;
  mphase_t    m_phase;
  int         m_cnt, m_slot, m_len;
  logic [3:0] m_take [$];
  logic [3:0] m_pk;
  logic       m_done;

  function automatic logic [1:0] mode_of(input mphase_t p);
    if (p == M_REC) return 2'b01;
    if (p == M_PLAY) return 2'b10;
    if (p == M_READY) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_cnt = 0; m_slot = 0; m_len = 0;
    m_take.delete(); m_pk = '0; m_done = 1'b0;
  endtask

  task automatic model_step();
    bit         tick;
    logic [3:0] pk_next;
    tick    = ((m_phase == M_REC) || (m_phase == M_PLAY)) && (m_cnt == TICK_DIV - 1);
    m_cnt   = (m_cnt + 1) % TICK_DIV;
    m_done  = 1'b0;
    pk_next = '0;
    case (m_phase)
      M_IDLE:     if (!bus.go) m_phase = M_ARM_REC;
      M_ARM_REC:  if (bus.go) begin m_phase = M_REC; m_take.delete(); m_slot = 0; m_cnt = 0; end
      M_REC: begin
        if (bus.stop) begin
          m_len = m_take.size();
          if (m_len > 0) begin m_phase = M_READY; m_done = 1'b1; end
          else m_phase = M_IDLE;
        end else if (tick) begin
          m_take.push_back(bus.keys);
          if (m_take.size() == DEPTH) begin m_len = DEPTH; m_done = 1'b1; m_phase = M_READY; end
          else m_slot = m_take.size();
        end
      end
      M_READY: begin
        if (bus.stop) begin m_len = 0; m_phase = M_IDLE; end
        else if (!bus.go) m_phase = M_ARM_PLAY;
      end
      M_ARM_PLAY: if (bus.go) begin m_phase = M_PLAY; m_slot = 0; m_cnt = 0; end
      M_PLAY: begin
        if (bus.stop) m_phase = M_READY;
        else begin
          pk_next = m_take[m_slot];
          if (tick) begin
            if (m_slot == m_len - 1) begin
              if (bus.loop) m_slot = 0;
              else begin m_phase = M_READY; m_done = 1'b1; pk_next = '0; end
            end else m_slot++;
          end
        end
      end
      default: m_phase = M_IDLE;
    endcase
    m_pk = pk_next;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       go;
    logic       stop;
    logic [3:0] keys;
    int         n;
    logic [1:0] mode;
    int         slot;     // -1: not checked
    int         rec_len;
    logic       done;
  } vec_t;
  vec_t vt [13];

  logic [3:0] pat  [8];
  logic [3:0] pat2 [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt, done_at, cyc, rand_err;
    logic [13:0] act_v, exp_v;

    pat  = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h9, 4'h6, 4'hF, 4'h1};
    pat2 = '{4'h6, 4'hE, 4'h2, 4'hB, 4'h7, 4'h8, 4'hD, 4'h4};

    vt[0]  = '{1'b0, 1'b0, 4'h0, 1, 2'd0,  0, 0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 4'h0, 1, 2'd1,  0, 0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 4'h0, 1, 2'd0,  0, 0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 4'h0, 1, 2'd0,  0, 0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 4'h0, 1, 2'd1,  0, 0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 4'h3, 8, 2'd1,  2, 0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 4'h3, 1, 2'd3,  2, 2, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 4'h3, 1, 2'd3,  2, 2, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 4'h3, 1, 2'd0, -1, 0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 4'h3, 1, 2'd0, -1, 0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 4'h3, 1, 2'd0, -1, 0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 4'h3, 1, 2'd1,  0, 0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 4'h3, 1, 2'd0,  0, 0, 1'b0};

    bus.go = 1'b1; bus.stop = 1'b0; bus.loop = 1'b0; bus.keys = '0;
    repeat (3) step();
    chk("rst_mode", 32'(bus.mode), 0);
    chk("rst_slot", 32'(bus.slot), 0);
    chk("rst_rec_len", 32'(bus.rec_len), 0);
    chk("rst_play_keys", 32'(bus.play_keys), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    step();

    // Table: stop at slot 0, short take, erase, ignored stops.
    for (int i = 0; i < 13; i++) begin
      bus.go = vt[i].go; bus.stop = vt[i].stop; bus.keys = vt[i].keys;
      repeat (vt[i].n) step();
      chk($sformatf("vec%0d_mode", i), 32'(bus.mode), 32'(vt[i].mode));
      chk($sformatf("vec%0d_rec_len", i), 32'(bus.rec_len), vt[i].rec_len);
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vt[i].done));
      if (vt[i].slot >= 0) chk($sformatf("vec%0d_slot", i), 32'(bus.slot), vt[i].slot);
    end
    bus.go = 1'b1; bus.stop = 1'b0;

    // Full 8-slot take.
    go_press();
    chk("t2_recording", 32'(bus.recording), 1);
    done_cnt = 0; done_at = -1; cyc = 0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.keys = pat[k];
      for (int c = 0; c < TICK_DIV; c++) begin
        step(); cyc++;
        if (bus.done) begin done_cnt++; done_at = cyc; end
      end
    end
    chk("t2_done_count", done_cnt, 1);
    chk("t2_done_cycle", done_at, 32);
    chk("t2_mode", 32'(bus.mode), 3);
    chk("t2_rec_len", 32'(bus.rec_len), 8);
    step();
    chk("t2_done_low", 32'(bus.done), 0);

    // One-shot playback.
    bus.loop = 1'b0;
    bus.go = 1'b0; step();
    chk("t3_arm_mode", 32'(bus.mode), 0);
    bus.go = 1'b1; step();
    chk("t3_play_mode", 32'(bus.mode), 2);
    chk("t3_playing_back", 32'(bus.playing_back), 1);
    chk("t3_pk_entry", 32'(bus.play_keys), 0);
    for (int j = 1; j <= 32; j++) begin
      step();
      if (j < 32) begin
        chk($sformatf("t3_pk_%0d", j), 32'(bus.play_keys), 32'(pat[(j - 1) / 4]));
        chk($sformatf("t3_done_%0d", j), 32'(bus.done), 0);
      end else begin
        chk("t3_end_pk", 32'(bus.play_keys), 0);
        chk("t3_end_mode", 32'(bus.mode), 3);
        chk("t3_end_done", 32'(bus.done), 1);
      end
    end
    step();
    chk("t3_done_low", 32'(bus.done), 0);
    chk("t3_rec_len_kept", 32'(bus.rec_len), 8);

    // Erase, then a take stopped on the tick of slot 3.
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("t4_erase_mode", 32'(bus.mode), 0);
    chk("t4_erase_len", 32'(bus.rec_len), 0);
    go_press();
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      bus.keys = pat2[k];
      for (int c = 0; c < TICK_DIV; c++) begin step(); if (bus.done) done_cnt++; end
    end
    bus.keys = pat2[3];
    repeat (TICK_DIV - 1) step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("t4_early_done", done_cnt, 0);
    chk("t4_mode", 32'(bus.mode), 3);
    chk("t4_rec_len", 32'(bus.rec_len), 3);
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_mem3_kept", 32'(dut.r_mem[3]), 32'(pat[3]));

    bus.loop = 1'b1;
    go_press();
    done_cnt = 0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (bus.done) done_cnt++;
      chk($sformatf("t4_slot_%0d", j), 32'(bus.slot), (j / 4) % 3);
      chk($sformatf("t4_pk_%0d", j), 32'(bus.play_keys), 32'(pat2[((j - 1) / 4) % 3]));
    end
    chk("t4_loop_no_done", done_cnt, 0);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("t4_stop_mode", 32'(bus.mode), 3);
    chk("t4_stop_pk", 32'(bus.play_keys), 0);
    chk("t4_stop_done", 32'(bus.done), 0);

    // Stop mid one-shot playback at slot 5.
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    go_press();
    for (int k = 0; k < DEPTH; k++) begin
      bus.keys = pat2[DEPTH - 1 - k];
      repeat (TICK_DIV) step();
    end
    chk("t6_rec_len", 32'(bus.rec_len), 8);
    bus.loop = 1'b0;
    go_press();
    repeat (20) step();
    chk("t6_slot", 32'(bus.slot), 5);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("t6_mode", 32'(bus.mode), 3);
    chk("t6_pk", 32'(bus.play_keys), 0);
    chk("t6_rec_len_kept", 32'(bus.rec_len), 8);
    chk("t6_no_done", 32'(bus.done), 0);
    bus.stop = 1'b1; step();
    chk("t6_erase_mode", 32'(bus.mode), 0);
    step(); bus.stop = 1'b0;
    chk("t6_idle_stop_mode", 32'(bus.mode), 0);
    chk("t6_idle_stop_len", 32'(bus.rec_len), 0);

    // Asynchronous reset in the middle of a take.
    go_press();
    repeat (12) step();
    chk("t1_slot_before", 32'(bus.slot), 3);
    #2 reset = 1'b0;
    #1;
    chk("t1_mode", 32'(bus.mode), 0);
    chk("t1_slot", 32'(bus.slot), 0);
    chk("t1_rec_len", 32'(bus.rec_len), 0);
    chk("t1_pk", 32'(bus.play_keys), 0);
    step();
    reset = 1'b1;
    model_reset();

    // Random stimulus against the reference model.
    rand_err = 0;
    for (int i = 0; i < 4000 && rand_err < 10; i++) begin
      bus.go   = ($urandom_range(0, 5) != 0);
      bus.stop = ($urandom_range(0, 39) == 0);
      bus.loop = 1'($urandom_range(0, 1));
      bus.keys = 4'($urandom);
      model_step();
      step();
      act_v = {bus.mode, bus.slot, bus.rec_len, bus.play_keys, bus.done};
      exp_v = {mode_of(m_phase), 3'(m_slot), 4'(m_len), m_pk, m_done};
      checks++;
      if (act_v !== exp_v) begin
        errors++; rand_err++;
        $display("FAIL rand_cycle_%0d {mode,slot,rec_len,pk,done}: got %h expected %h", i, act_v, exp_v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/keyloop_recorder.md
Name: keyloop_recorder

Overview:
- Parametrised key-pattern recorder/player for the synthesizer front end.
- Samples the KEY_W-bit key vector once per tick into an internal DEPTH-entry memory, then replays it.
- Supports early stop, recorded-length tracking, one-shot or looped playback, and erase.
- Sits between the key debouncer and the tone generator; play_keys is muxed with live keys downstream.

Parameters:
- KEY_W, 4, width of key vector and of each memory word
- DEPTH, 32, number of memory slots (>=2)
- ADDR_W, 5, slot address width; DEPTH <= 2**ADDR_W
- TICK_DIV, 50000000, clock cycles per slot (>=2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- go  in  1  active-low push button; a press is go low followed by go high
- stop  in  1  active-high, single-cycle abort/erase request
- loop  in  1  1 = playback wraps to slot 0; sampled at each end-of-take
- keys  in  KEY_W  live key vector to record
- mode  out  2  00 idle/armed, 01 recording, 10 playing, 11 ready
- recording  out  1  high in REC
- playing_back  out  1  high in PLAY
- play_keys  out  KEY_W  replayed key vector; 0 outside PLAY
- slot  out  ADDR_W  current slot index
- rec_len  out  ADDR_W+1  number of valid recorded slots, 0..DEPTH
- done  out  1  one-cycle pulse at end of a take or a one-shot playback

Behaviour:
- Reset values: state IDLE; slot, tick counter, rec_len, play_keys and done all 0; mode 00. Memory contents are not reset.
- States: IDLE, ARM_REC, REC, READY, ARM_PLAY, PLAY. All outputs registered except mode, recording and playing_back, which decode the state.
- IDLE: go==0 -> ARM_REC.
- ARM_REC: go==1 -> REC. On entry to REC, slot and the tick counter are cleared to 0.
- Tick counter: counts 0..TICK_DIV-1 only in REC and PLAY. A tick is the cycle with count==TICK_DIV-1; the counter then wraps to 0. The first tick occurs TICK_DIV cycles after state entry.
- REC, on each tick:
  - mem[slot] <= keys.
  - If slot==DEPTH-1: rec_len <= DEPTH, done pulses, -> READY.
  - Otherwise slot <= slot+1.
- REC, stop==1:
  - rec_len <= slot (count of slots already written; the current partial slot is discarded).
  - If slot>0 -> READY with done pulse; otherwise -> IDLE with no done pulse.
  - If stop and a tick coincide, stop wins and no write occurs.
- READY:
  - go==0 -> ARM_PLAY.
  - stop==1 -> IDLE with rec_len <= 0 (erase).
  - If go==0 and stop==1 in the same cycle, stop wins.
- ARM_PLAY: go==1 -> PLAY; slot and tick counter cleared to 0.
- PLAY, every cycle: play_keys <= mem[slot]. This gives 1-cycle read latency, so play_keys is valid from the 2nd cycle in PLAY.
- PLAY, on each tick:
  - If slot==rec_len-1 and loop==1: slot <= 0 and stay in PLAY; no done pulse.
  - If slot==rec_len-1 and loop==0: -> READY, done pulses, play_keys <= 0.
  - Otherwise slot <= slot+1.
- PLAY, stop==1: -> READY, play_keys <= 0, no done pulse. Stop has priority over a coincident tick.
- stop is ignored in IDLE, ARM_REC and ARM_PLAY.
- rec_len is retained across playbacks; a new recording requires an erase first.
- Asynchronous reset mid-REC or mid-PLAY returns immediately to IDLE with rec_len=0. Memory contents are undefined but harmless because rec_len=0.
- Width rules: slot never exceeds DEPTH-1; rec_len is ADDR_W+1 bits wide so it can hold DEPTH.

Test Plan (TICK_DIV=4, DEPTH=8, KEY_W=4):
1. Reset asserted mid-REC at slot 3 -> next edge-independent sample shows mode=00, slot=0, rec_len=0, play_keys=0.
2. Go press; hold keys=4'hA for slot 0, 4'h5 for slot 1, and so on; run 8 ticks -> rec_len=8, done pulses exactly once 32 cycles after REC entry, mode=11.
3. From READY with rec_len=8, go press, loop=0 -> play_keys reproduces the recorded sequence, each value held 4 cycles, starting 1 cycle after PLAY entry. After 8 ticks: mode=11, done pulses once, play_keys=0.
4. Record with stop pulsed at slot 3 (coinciding with a tick) -> rec_len=3, mem[3] unchanged, mode=11. Play with loop=1 -> slot sequence 0,1,2,0,1,2…; no done pulse.
5. Stop pulsed in REC at slot 0 -> mode=00, rec_len=0, no done. In READY, go==0 together with stop==1 -> IDLE, rec_len=0.
6. During PLAY, stop pulsed at slot 5 -> READY next cycle, play_keys=0, rec_len unchanged, no done. Then stop in IDLE -> no effect.
